// File: rtl/instmem_pkg.sv
// Shared types, constants and helpers for the instruction memory fetch unit.
package instmem_pkg;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } state_e;

  // Widest word the parity helper accepts; narrower words are zero-extended.
  localparam int PAR_MAX_W = 256;

  localparam logic [PAR_MAX_W-1:0] NOP_DEFAULT = '0;

  // Even-parity bit: makes the total count of ones (data + bit) even.
  function automatic logic even_parity(input logic [PAR_MAX_W-1:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/instmem_ram.sv
// Synchronous 1-read/1-write array, read-first; the read register holds while rd_en is low.
module instmem_ram #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 1024,
  parameter int IDX_W = 10
) (
  input  logic             clk,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  input  logic [IDX_W-1:0] rd_addr,
  output logic [WIDTH-1:0] rd_data
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] rd_data_q;

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_addr] <= wr_data;
    if (rd_en) rd_data_q <= mem_q[rd_addr];
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/instmem_fetch_unit.sv
// Instruction fetch unit: clears the RAM to NOP_WORD after reset, then serves 1-cycle fetches with stall hold.
// Optional per-word even parity with fault injection when INSTMEM_PARITY_EN is defined.
module instmem_fetch_unit
  import instmem_pkg::*;
#(
  parameter int                    DATA_WIDTH = 32,
  parameter int                    ADDR_WIDTH = 10,
  parameter int                    DEPTH      = 1024,
  parameter logic [DATA_WIDTH-1:0] NOP_WORD   = NOP_DEFAULT[DATA_WIDTH-1:0]
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  fetch_req,
  input  logic [ADDR_WIDTH-1:0] fetch_addr,
  input  logic                  fetch_stall,
  output logic                  fetch_ready,
  output logic                  fetch_valid,
  output logic [DATA_WIDTH-1:0] fetch_data,
  output logic                  fetch_err,
  input  logic                  prog_we,
  input  logic [ADDR_WIDTH-1:0] prog_addr,
  input  logic [DATA_WIDTH-1:0] prog_data,
`ifdef INSTMEM_PARITY_EN
  input  logic                  par_inject,
`endif
  output logic                  init_done
);

  localparam int unsigned DEPTH_U = DEPTH;
  localparam int          IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
`ifdef INSTMEM_PARITY_EN
  localparam int          RAM_W   = DATA_WIDTH + 1;
`else
  localparam int          RAM_W   = DATA_WIDTH;
`endif

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] clr_cnt_q, clr_cnt_d;
  logic                  valid_q, valid_d;
  logic                  hit_q, hit_d;  // last accepted fetch was in range, so the RAM output is live
  logic                  oor_q, oor_d;

  logic                  fetch_in_range, prog_in_range;
  logic                  ram_we, ram_re;
  logic [IDX_W-1:0]      ram_wa;
  logic [DATA_WIDTH-1:0] wr_word;
  logic [RAM_W-1:0]      ram_wd, ram_rd;
  logic                  par_err;

  assign fetch_in_range = 32'(fetch_addr) < DEPTH_U;
  assign prog_in_range  = 32'(prog_addr) < DEPTH_U;

  always_comb begin
    state_d     = state_q;
    clr_cnt_d   = clr_cnt_q;
    valid_d     = valid_q;
    hit_d       = hit_q;
    oor_d       = oor_q;
    fetch_ready = 1'b0;
    init_done   = 1'b0;
    ram_we      = 1'b0;
    ram_wa      = clr_cnt_q[IDX_W-1:0];
    wr_word     = NOP_WORD;
    case (state_q)
      ST_CLEAR: begin
        ram_we    = 1'b1;
        clr_cnt_d = clr_cnt_q + ADDR_WIDTH'(1);
        if (32'(clr_cnt_q) == DEPTH_U - 1) begin
          state_d   = ST_RUN;
          clr_cnt_d = '0;
        end
      end
      ST_RUN: begin
        init_done   = 1'b1;
        fetch_ready = ~(valid_q & fetch_stall);
        ram_we      = prog_we & prog_in_range;
        ram_wa      = prog_addr[IDX_W-1:0];
        wr_word     = prog_data;
        if (fetch_ready) begin
          valid_d = fetch_req;
          if (fetch_req) begin
            hit_d = fetch_in_range;
            oor_d = ~fetch_in_range;
          end
        end
      end
      default: ;
    endcase
  end

  // Reads only on accepted in-range fetches, so a stall freezes the RAM output register.
  assign ram_re = fetch_req & fetch_ready & fetch_in_range;

`ifdef INSTMEM_PARITY_EN
  logic wr_par;
  always_comb begin
    wr_par = even_parity(PAR_MAX_W'(wr_word));
    if (state_q == ST_RUN && par_inject) wr_par = ~wr_par;
  end
  assign ram_wd  = {wr_par, wr_word};
  assign par_err = hit_q &
                   (ram_rd[DATA_WIDTH] != even_parity(PAR_MAX_W'(ram_rd[DATA_WIDTH-1:0])));
`else
  assign ram_wd  = wr_word;
  assign par_err = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_CLEAR;
      clr_cnt_q <= '0;
      valid_q   <= 1'b0;
      hit_q     <= 1'b0;
      oor_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
      valid_q   <= valid_d;
      hit_q     <= hit_d;
      oor_q     <= oor_d;
    end
  end

  instmem_ram #(
    .WIDTH (RAM_W),
    .DEPTH (DEPTH),
    .IDX_W (IDX_W)
  ) u_ram (
    .clk     (clk),
    .wr_en   (ram_we),
    .wr_addr (ram_wa),
    .wr_data (ram_wd),
    .rd_en   (ram_re),
    .rd_addr (fetch_addr[IDX_W-1:0]),
    .rd_data (ram_rd)
  );

  assign fetch_valid = valid_q;
  assign fetch_err   = oor_q | par_err;
  assign fetch_data  = (hit_q && !par_err) ? ram_rd[DATA_WIDTH-1:0] : NOP_WORD;

endmodule

// File: tb/tb_instmem_fetch_unit.sv
// Directed bench for instmem_fetch_unit with DEPTH=16: vector table plus clear, stall, reset and parity sequences.
module tb_instmem_fetch_unit;

  localparam int DW    = 32;
  localparam int AW    = 10;
  localparam int DEPTH = 16;

  logic          clk         = 1'b0;
  logic          rst_n       = 1'b1;
  logic          fetch_req   = 1'b0;
  logic [AW-1:0] fetch_addr  = '0;
  logic          fetch_stall = 1'b0;
  logic          prog_we     = 1'b0;
  logic [AW-1:0] prog_addr   = '0;
  logic [DW-1:0] prog_data   = '0;
`ifdef INSTMEM_PARITY_EN
  logic          par_inject  = 1'b0;
`endif
  logic          fetch_ready, fetch_valid, fetch_err, init_done;
  logic [DW-1:0] fetch_data;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  instmem_fetch_unit #(
    .DATA_WIDTH (DW),
    .ADDR_WIDTH (AW),
    .DEPTH      (DEPTH)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .fetch_req   (fetch_req),
    .fetch_addr  (fetch_addr),
    .fetch_stall (fetch_stall),
    .fetch_ready (fetch_ready),
    .fetch_valid (fetch_valid),
    .fetch_data  (fetch_data),
    .fetch_err   (fetch_err),
    .prog_we     (prog_we),
    .prog_addr   (prog_addr),
    .prog_data   (prog_data),
`ifdef INSTMEM_PARITY_EN
    .par_inject  (par_inject),
`endif
    .init_done   (init_done)
  );

  typedef struct {
    logic          req;
    logic [AW-1:0] addr;
    logic          stall;
    logic          we;
    logic [AW-1:0] paddr;
    logic [DW-1:0] pdata;
    logic          rdy;
    logic          vld;
    logic [DW-1:0] data;
    logic          err;
  } vec_t;

  localparam int NVEC = 15;
  vec_t          vecs [NVEC];
  logic [DW-1:0] model [DEPTH];

  function automatic vec_t mk(input logic req, input logic [AW-1:0] addr, input logic stall,
                              input logic we, input logic [AW-1:0] paddr, input logic [DW-1:0] pdata,
                              input logic rdy, input logic vld, input logic [DW-1:0] data,
                              input logic err);
    vec_t v;
    v.req = req; v.addr = addr; v.stall = stall; v.we = we; v.paddr = paddr; v.pdata = pdata;
    v.rdy = rdy; v.vld = vld; v.data = data; v.err = err;
    return v;
  endfunction

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%h, expected 0x%h", name, act, exp);
    end
  endtask

  task automatic apply(input vec_t v, input int i);
    fetch_req   = v.req;
    fetch_addr  = v.addr;
    fetch_stall = v.stall;
    prog_we     = v.we;
    prog_addr   = v.paddr;
    prog_data   = v.pdata;
    #1;
    check($sformatf("vec%0d_ready", i), 32'(fetch_ready), 32'(v.rdy));
    @(posedge clk); #1;
    check($sformatf("vec%0d_valid", i), 32'(fetch_valid), 32'(v.vld));
    if (v.vld) begin
      check($sformatf("vec%0d_data", i), fetch_data, v.data);
      check($sformatf("vec%0d_err", i), 32'(fetch_err), 32'(v.err));
    end
  endtask

  task automatic fetch(input logic [AW-1:0] a, input logic [DW-1:0] exp_d, input logic exp_e,
                       input string name);
    fetch_req   = 1'b1;
    fetch_addr  = a;
    fetch_stall = 1'b0;
    prog_we     = 1'b0;
    #1;
    check({name, "_ready"}, 32'(fetch_ready), 32'd1);
    @(posedge clk); #1;
    check({name, "_valid"}, 32'(fetch_valid), 32'd1);
    check({name, "_data"}, fetch_data, exp_d);
    check({name, "_err"}, 32'(fetch_err), 32'(exp_e));
    fetch_req = 1'b0;
  endtask

  task automatic prog_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
    fetch_req = 1'b0;
    prog_we   = 1'b1;
    prog_addr = a;
    prog_data = d;
    @(posedge clk); #1;
    prog_we = 1'b0;
  endtask

  // Counts rising edges after reset release until init_done; fetch_ready must stay low meanwhile.
  task automatic wait_init(input string name);
    int n;
    bit rdy_seen;
    n        = 0;
    rdy_seen = 1'b0;
    while (n < 64) begin
      @(posedge clk); #1;
      n++;
      if (init_done) break;
      if (fetch_ready) rdy_seen = 1'b1;
    end
    check({name, "_cycles"}, 32'(n), 32'd16);
    check({name, "_ready_in_clear"}, 32'(rdy_seen), 32'd0);
  endtask

  task automatic check_reset_outputs(input string name);
    check({name, "_valid"}, 32'(fetch_valid), 32'd0);
    check({name, "_data"}, fetch_data, 32'h0);
    check({name, "_err"}, 32'(fetch_err), 32'd0);
    check({name, "_ready"}, 32'(fetch_ready), 32'd0);
    check({name, "_init"}, 32'(init_done), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached before end of test");
    $fatal(1);
  end

  initial begin
    //       req addr    stl we  paddr   pdata          rdy vld data           err
    vecs[0]  = mk(1'b0, 10'd0,    1'b0, 1'b1, 10'd7,  32'h0C10A500, 1'b1, 1'b0, 32'h0,        1'b0);
    vecs[1]  = mk(1'b1, 10'd7,    1'b0, 1'b0, 10'd0,  32'h0,        1'b1, 1'b1, 32'h0C10A500, 1'b0);
    vecs[2]  = mk(1'b0, 10'd0,    1'b0, 1'b1, 10'd5,  32'h22222222, 1'b1, 1'b0, 32'h0,        1'b0);
    vecs[3]  = mk(1'b1, 10'd5,    1'b0, 1'b1, 10'd5,  32'h11111111, 1'b1, 1'b1, 32'h22222222, 1'b0);
    vecs[4]  = mk(1'b1, 10'd5,    1'b0, 1'b0, 10'd0,  32'h0,        1'b1, 1'b1, 32'h11111111, 1'b0);
    vecs[5]  = mk(1'b1, 10'd4,    1'b0, 1'b0, 10'd0,  32'h0,        1'b1, 1'b1, 32'h0,        1'b0);
    vecs[6]  = mk(1'b1, 10'd20,   1'b0, 1'b1, 10'd20, 32'hFFFFFFFF, 1'b1, 1'b1, 32'h0,        1'b1);
    vecs[7]  = mk(1'b1, 10'd4,    1'b0, 1'b0, 10'd0,  32'h0,        1'b1, 1'b1, 32'h0,        1'b0);
    vecs[8]  = mk(1'b1, 10'd16,   1'b0, 1'b0, 10'd0,  32'h0,        1'b1, 1'b1, 32'h0,        1'b1);
    vecs[9]  = mk(1'b1, 10'd15,   1'b0, 1'b1, 10'd15, 32'hF00DF00D, 1'b1, 1'b1, 32'h0,        1'b0);
    vecs[10] = mk(1'b1, 10'd15,   1'b0, 1'b0, 10'd0,  32'h0,        1'b1, 1'b1, 32'hF00DF00D, 1'b0);
    vecs[11] = mk(1'b1, 10'd1023, 1'b0, 1'b0, 10'd0,  32'h0,        1'b1, 1'b1, 32'h0,        1'b1);
    vecs[12] = mk(1'b1, 10'd7,    1'b0, 1'b0, 10'd0,  32'h0,        1'b1, 1'b1, 32'h0C10A500, 1'b0);
    vecs[13] = mk(1'b0, 10'd0,    1'b0, 1'b1, 10'd3,  32'h33333333, 1'b1, 1'b0, 32'h0,        1'b0);
    vecs[14] = mk(1'b1, 10'd3,    1'b1, 1'b0, 10'd0,  32'h0,        1'b1, 1'b1, 32'h33333333, 1'b0);

    for (int k = 0; k < DEPTH; k++) model[k] = 32'h0;
    model[3]  = 32'h33333333;
    model[5]  = 32'h11111111;
    model[7]  = 32'h0C10A500;
    model[15] = 32'hF00DF00D;

    // Power-on reset; program port and fetch request are driven throughout the clear.
    #1 rst_n = 1'b0;
    #2 check_reset_outputs("por");
    prog_we   = 1'b1;
    prog_addr = 10'd4;
    prog_data = 32'hDEADBEEF;
    fetch_req = 1'b1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    wait_init("clear");
    prog_we   = 1'b0;
    fetch_req = 1'b0;

    for (int k = 0; k < DEPTH; k++) fetch(AW'(k), 32'h0, 1'b0, $sformatf("init%0d", k));

    for (int i = 0; i < NVEC; i++) apply(vecs[i], i);

    for (int k = 0; k < DEPTH; k++) fetch(AW'(k), model[k], 1'b0, $sformatf("sweep%0d", k));

    // Stall hold: new address and a program write arrive while the consumer holds.
    fetch(10'd3, 32'h33333333, 1'b0, "stall_first");
    fetch_stall = 1'b1;
    fetch_req   = 1'b1;
    fetch_addr  = 10'd7;
    prog_we     = 1'b1;
    prog_addr   = 10'd9;
    prog_data   = 32'h99999999;
    for (int k = 0; k < 4; k++) begin
      #1;
      check($sformatf("stall%0d_ready", k), 32'(fetch_ready), 32'd0);
      @(posedge clk); #1;
      prog_we = 1'b0;
      check($sformatf("stall%0d_valid", k), 32'(fetch_valid), 32'd1);
      check($sformatf("stall%0d_data", k), fetch_data, 32'h33333333);
      check($sformatf("stall%0d_err", k), 32'(fetch_err), 32'd0);
    end
    fetch_stall = 1'b0;
    #1;
    check("unstall_ready", 32'(fetch_ready), 32'd1);
    @(posedge clk); #1;
    check("unstall_valid", 32'(fetch_valid), 32'd1);
    check("unstall_data", fetch_data, 32'h0C10A500);
    fetch_req = 1'b0;
    fetch(10'd9, 32'h99999999, 1'b0, "write_during_stall");

    // Reset mid-RUN while outputs carry a non-NOP word.
    fetch(10'd5, 32'h11111111, 1'b0, "pre_reset");
    rst_n = 1'b0;
    #1 check_reset_outputs("midrun_rst");
    @(posedge clk); #1;
    rst_n = 1'b1;
    wait_init("reclear");
    fetch(10'd5, 32'h0, 1'b0, "reclear_addr5");
    fetch(10'd7, 32'h0, 1'b0, "reclear_addr7");

`ifdef INSTMEM_PARITY_EN
    par_inject = 1'b1;
    prog_write(10'd2, 32'h12345678);
    par_inject = 1'b0;
    fetch(10'd2, 32'h0, 1'b1, "par_fault");
    prog_write(10'd2, 32'h12345678);
    fetch(10'd2, 32'h12345678, 1'b0, "par_rewrite");
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
